// File: rtl/motor_pkg.sv
// Shared types and helpers for the multi-channel signed-command PWM motor driver.
// Direction decode and the dead-time rule live here so every channel applies the same policy.
package motor_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FWD   = 3'd1,
        REV   = 3'd2,
        BRAKE = 3'd3,
        DEAD  = 3'd4
    } mot_state_t;

    // Target drive state implied by the sign of a latched command.
    function automatic mot_state_t tgt_dir(input logic neg, input logic zero, input logic brk_zero);
        if (zero) begin
            return brk_zero ? BRAKE : IDLE;
        end else if (neg) begin
            return REV;
        end else begin
            return FWD;
        end
    endfunction

    // Only IDLE may jump straight to a new state; any change away from a driven state gets dead time.
    function automatic logic needs_dead(input mot_state_t cur, input mot_state_t tgt);
        return (cur != IDLE) && (cur != tgt);
    endfunction

endpackage

// File: rtl/motor_pwm_chan.sv
// One motor channel: period-boundary command latch, saturating magnitude,
// direction FSM with dead time, and registered fwd/rev/busy outputs.
module motor_pwm_chan
    import motor_pkg::*;
#(
    parameter int W        = 12,
    parameter int DEAD_CYC = 16,
    parameter int BRK_ZERO = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-2:0] cnt,
    input  logic         wrap,
    input  logic [W-1:0] cmd,
    output logic         fwd,
    output logic         rev,
    output logic         busy
);

    localparam int CW = W - 1;
    localparam int DW = $clog2(DEAD_CYC + 1);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYC - 1);

    mot_state_t    state_q, state_d;
    mot_state_t    dead_tgt_q, dead_tgt_d;
    logic [DW-1:0] dead_cnt_q, dead_cnt_d;
    logic [W-1:0]  cmd_q, cmd_d;
    logic          fwd_q, fwd_d;
    logic          rev_q, rev_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] mag;
    mot_state_t    tgt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dead_tgt_q <= IDLE;
            dead_cnt_q <= '0;
            cmd_q      <= '0;
            fwd_q      <= 1'b0;
            rev_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dead_tgt_q <= dead_tgt_d;
            dead_cnt_q <= dead_cnt_d;
            cmd_q      <= cmd_d;
            fwd_q      <= fwd_d;
            rev_q      <= rev_d;
            busy_q     <= busy_d;
        end
    end

    // The most negative command has no positive twin; it saturates to full scale.
    always_comb begin
        cmd_d = wrap ? cmd : cmd_q;
        if (!cmd_q[W-1]) begin
            mag = cmd_q[CW-1:0];
        end else if (cmd_q[CW-1:0] == '0) begin
            mag = '1;
        end else begin
            mag = ~cmd_q[CW-1:0] + CW'(1);
        end
        tgt = tgt_dir(cmd_q[W-1], cmd_q == '0, BRK_ZERO != 0);
    end

    always_comb begin
        state_d    = state_q;
        dead_tgt_d = dead_tgt_q;
        dead_cnt_d = dead_cnt_q;
        if (!en) begin
            state_d    = IDLE;
            dead_cnt_d = '0;
        end else if (state_q == DEAD) begin
            // The target was frozen on entry; a newer command is judged after exit.
            if (dead_cnt_q == '0) begin
                state_d = dead_tgt_q;
            end else begin
                dead_cnt_d = dead_cnt_q - DW'(1);
            end
        end else if (tgt != state_q) begin
            if (needs_dead(state_q, tgt)) begin
                state_d    = DEAD;
                dead_tgt_d = tgt;
                dead_cnt_d = DEAD_LOAD;
            end else begin
                state_d = tgt;
            end
        end
    end

    always_comb begin
        fwd_d  = 1'b0;
        rev_d  = 1'b0;
        busy_d = 1'b0;
        if (en) begin
            case (state_q)
                FWD:     fwd_d = (cnt < mag);
                REV:     rev_d = (cnt < mag);
                BRAKE: begin
                    fwd_d = 1'b1;
                    rev_d = 1'b1;
                end
                DEAD:    busy_d = 1'b1;
                default: ;
            endcase
        end
    end

    assign fwd  = fwd_q;
    assign rev  = rev_q;
    assign busy = busy_q;

endmodule

// File: rtl/motor_pwm_multi.sv
// N-channel signed-command PWM motor driver: one shared period counter feeding
// independent per-channel direction/dead-time engines.
module motor_pwm_multi
    import motor_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int W        = 12,
    parameter int DEAD_CYC = 16,
    parameter int BRK_ZERO = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [NCH*W-1:0] cmd,
    output logic [NCH-1:0]   fwd,
    output logic [NCH-1:0]   rev,
    output logic [NCH-1:0]   busy
);

    localparam int CW = W - 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Natural binary rollover gives the max->0 wrap; wrap marks the command-sampling cycle.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        wrap  = &cnt_q;
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        motor_pwm_chan #(
            .W        (W),
            .DEAD_CYC (DEAD_CYC),
            .BRK_ZERO (BRK_ZERO)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .cnt   (cnt_q),
            .wrap  (wrap),
            .cmd   (cmd[gi*W +: W]),
            .fwd   (fwd[gi]),
            .rev   (rev[gi]),
            .busy  (busy[gi])
        );
    end

endmodule
